// File: rtl/full_adder_pkg.sv
// Shared constants, result type and a reference add function for full_adder.
// Optional signed-overflow outputs are enabled by defining FULL_ADDER_OVF_EN.
package full_adder_pkg;

  // Default operand width: the classic 1-bit full adder.
  localparam int unsigned FA_DEFAULT_WIDTH = 1;

  // Widest operand the reference function can model.
  localparam int unsigned FA_REF_MAX_WIDTH = 64;

  typedef struct packed {
    logic                        cout;
    logic [FA_REF_MAX_WIDTH-1:0] sum;
  } fa_result_t;

  // Reference {cout,sum} of a + b + cin at a given width (1..FA_REF_MAX_WIDTH).
  // Operand bits above 'width' are ignored so callers may pass wider values.
  function automatic fa_result_t fa_ref_add(input logic [FA_REF_MAX_WIDTH-1:0] a,
                                            input logic [FA_REF_MAX_WIDTH-1:0] b,
                                            input logic                        cin,
                                            input int unsigned                 width);
    logic [FA_REF_MAX_WIDTH-1:0] mask;
    logic [FA_REF_MAX_WIDTH:0]   full;
    fa_result_t                  res;
    if (width >= FA_REF_MAX_WIDTH) begin
      mask = '1;
    end else begin
      mask = (FA_REF_MAX_WIDTH'(1) << width) - FA_REF_MAX_WIDTH'(1);
    end
    full = {1'b0, a & mask} + {1'b0, b & mask} + {{FA_REF_MAX_WIDTH{1'b0}}, cin};
    res.sum = full[FA_REF_MAX_WIDTH-1:0] & mask;
    if (width >= FA_REF_MAX_WIDTH) begin
      res.cout = full[FA_REF_MAX_WIDTH];
    end else begin
      res.cout = full[width];
    end
    return res;
  endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder cell; chained by full_adder to form a ripple-carry adder.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  logic p;

  // Propagate term shared by sum and carry.
  always_comb begin
    p     = a ^ b;
    s     = p ^ c_in;
    c_out = (a & b) | (c_in & p);
  end

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder with a combinational result and a one-stage registered copy.
// Define FULL_ADDER_OVF_EN to add the signed-overflow outputs ovf and ovf_q.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry-out.
  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_bit u_fa_bit (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (carry[i]),
      .s     (sum[i]),
      .c_out (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovf = carry[WIDTH] ^ carry[WIDTH-1];
`endif

  // Registered copy: valid always tracks in_valid, data only moves on valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q     <= '0;
      cout_q    <= 1'b0;
      out_valid <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q  <= sum;
        cout_q <= cout;
`ifdef FULL_ADDER_OVF_EN
        ovf_q  <= ovf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH 1, 8 and 16.
module tb_full_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // WIDTH = 1 instance
  logic [0:0]  a1, b1, sum1, sum_q1;
  logic        cin1, cout1, in_valid1, cout_q1, out_valid1;
  // WIDTH = 8 instance
  logic [7:0]  a8, b8, sum8, sum_q8;
  logic        cin8, cout8, in_valid8, cout_q8, out_valid8;
  // WIDTH = 16 instance
  logic [15:0] a16, b16, sum16, sum_q16;
  logic        cin16, cout16, in_valid16, cout_q16, out_valid16;
`ifdef FULL_ADDER_OVF_EN
  logic ovf1, ovf_q1, ovf8, ovf_q8, ovf16, ovf_q16;
`endif

  int vectors = 0;
  int miscompares = 0;

  full_adder #(.WIDTH(1)) u_w1 (
    .a(a1), .b(b1), .cin(cin1), .sum(sum1), .cout(cout1),
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1),
    .sum_q(sum_q1), .cout_q(cout_q1), .out_valid(out_valid1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf1), .ovf_q(ovf_q1)
`endif
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .a(a8), .b(b8), .cin(cin8), .sum(sum8), .cout(cout8),
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8),
    .sum_q(sum_q8), .cout_q(cout_q8), .out_valid(out_valid8)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf8), .ovf_q(ovf_q8)
`endif
  );

  full_adder #(.WIDTH(16)) u_w16 (
    .a(a16), .b(b16), .cin(cin16), .sum(sum16), .cout(cout16),
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16),
    .sum_q(sum_q16), .cout_q(cout_q16), .out_valid(out_valid16)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf16), .ovf_q(ovf_q16)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exhaustive 1-bit truth table, no clock edges involved.
  task automatic test_comb_sweep();
    logic [1:0] exp;
    for (int i = 0; i < 8; i++) begin
      a1   = 1'(i >> 2);
      b1   = 1'(i >> 1);
      cin1 = 1'(i);
      #1;
      exp = 2'(((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1));
      vectors++;
      if ({cout1, sum1} !== exp) begin
        miscompares++;
        $display("FAIL comb_sweep abc=%0d got {cout,sum}=%b want %b", i, {cout1, sum1}, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    tick();
    tick();
    vectors++;
    if ({sum_q1, cout_q1, out_valid1} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_w1 got {sum_q,cout_q,out_valid}=%b want 000",
               {sum_q1, cout_q1, out_valid1});
    end
    vectors++;
    if ({sum_q8, cout_q8, out_valid8} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_w8 got sum_q=%h cout_q=%b out_valid=%b want 0 0 0",
               sum_q8, cout_q8, out_valid8);
    end
    vectors++;
    if ({sum_q16, cout_q16, out_valid16} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_w16 got sum_q=%h cout_q=%b out_valid=%b want 0 0 0",
               sum_q16, cout_q16, out_valid16);
    end
`ifdef FULL_ADDER_OVF_EN
    vectors++;
    if ({ovf_q1, ovf_q8, ovf_q16} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ovf_q got %b want 000", {ovf_q1, ovf_q8, ovf_q16});
    end
`endif
    rst_n = 1'b1;
    tick();
    vectors++;
    if ({sum_q1, cout_q1, out_valid1} !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_release got {sum_q,cout_q,out_valid}=%b want 111",
               {sum_q1, cout_q1, out_valid1});
    end
    in_valid1 = 1'b0;
  endtask

  // Boundary sums at WIDTH=8, combinational only.
  task automatic test_wrap();
    logic [7:0] ta [4] = '{8'hFF, 8'hFF, 8'h00, 8'h7F};
    logic [7:0] tb [4] = '{8'h00, 8'hFF, 8'h00, 8'h01};
    logic       tc [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [8:0] exp;
    for (int i = 0; i < 4; i++) begin
      a8 = ta[i]; b8 = tb[i]; cin8 = tc[i];
      #1;
      exp = 9'(int'(ta[i]) + int'(tb[i]) + int'(tc[i]));
      vectors++;
      if ({cout8, sum8} !== exp) begin
        miscompares++;
        $display("FAIL wrap_%0d got cout=%b sum=%h want cout=%b sum=%h",
                 i, cout8, sum8, exp[8], exp[7:0]);
      end
`ifdef FULL_ADDER_OVF_EN
      begin
        logic eo;
        eo = (ta[i][7] == tb[i][7]) && (exp[7] != ta[i][7]);
        vectors++;
        if (ovf8 !== eo) begin
          miscompares++;
          $display("FAIL wrap_ovf_%0d got %b want %b", i, ovf8, eo);
        end
      end
`endif
    end
  endtask

  task automatic test_capture_hold();
    in_valid8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    tick();
    vectors++;
    if ({sum_q8, cout_q8, out_valid8} !== {8'h46, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL capture got sum_q=%h cout_q=%b out_valid=%b want 46 0 1",
               sum_q8, cout_q8, out_valid8);
    end
    in_valid8 = 1'b0; a8 = 8'hFF;
    tick();
    vectors++;
    if ({sum_q8, cout_q8, out_valid8} !== {8'h46, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL hold got sum_q=%h cout_q=%b out_valid=%b want 46 0 0",
               sum_q8, cout_q8, out_valid8);
    end
  endtask

  task automatic test_reset_drop();
    rst_n = 1'b0;
    in_valid8 = 1'b1; a8 = 8'd3; b8 = 8'd4; cin8 = 1'b0;
    tick();
    vectors++;
    if ({sum_q8, cout_q8, out_valid8} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_drop got sum_q=%h cout_q=%b out_valid=%b want 0 0 0",
               sum_q8, cout_q8, out_valid8);
    end
    rst_n = 1'b1;
    in_valid8 = 1'b0;
    tick();
    vectors++;
    if (out_valid8 !== 1'b0 || sum_q8 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_drop_after got sum_q=%h out_valid=%b want 0 0", sum_q8, out_valid8);
    end
  endtask

  // Random traffic at WIDTH=16 against an arithmetic model with a one-entry pipe.
  task automatic test_random();
    logic [16:0] full;
    logic [15:0] exp_sum_q = '0;
    logic        exp_cout_q = 1'b0;
    logic        exp_valid;
    logic        v;
    logic        eo;
    logic        exp_ovf_q = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      cin16 = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 3) != 0);
      in_valid16 = v;
      #1;
      full = 17'(int'(a16) + int'(b16) + int'(cin16));
      eo = (a16[15] == b16[15]) && (full[15] != a16[15]);
      vectors++;
      if ({cout16, sum16} !== full) begin
        miscompares++;
        $display("FAIL rand_comb #%0d a=%h b=%h cin=%b got cout=%b sum=%h want cout=%b sum=%h",
                 i, a16, b16, cin16, cout16, sum16, full[16], full[15:0]);
      end
`ifdef FULL_ADDER_OVF_EN
      vectors++;
      if (ovf16 !== eo) begin
        miscompares++;
        $display("FAIL rand_ovf #%0d got %b want %b", i, ovf16, eo);
      end
`endif
      if (v) begin
        exp_sum_q  = full[15:0];
        exp_cout_q = full[16];
        exp_ovf_q  = eo;
      end
      exp_valid = v;
      tick();
      vectors++;
      if ({sum_q16, cout_q16, out_valid16} !== {exp_sum_q, exp_cout_q, exp_valid}) begin
        miscompares++;
        $display("FAIL rand_reg #%0d got sum_q=%h cout_q=%b out_valid=%b want %h %b %b",
                 i, sum_q16, cout_q16, out_valid16, exp_sum_q, exp_cout_q, exp_valid);
      end
`ifdef FULL_ADDER_OVF_EN
      vectors++;
      if (ovf_q16 !== exp_ovf_q) begin
        miscompares++;
        $display("FAIL rand_ovf_q #%0d got %b want %b", i, ovf_q16, exp_ovf_q);
      end
`endif
    end
    in_valid16 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0; in_valid1 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0; in_valid8 = 1'b0;
    a16 = '0; b16 = '0; cin16 = 1'b0; in_valid16 = 1'b0;
    test_comb_sweep();
    test_reset();
    test_wrap();
    test_capture_hold();
    test_reset_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Carry-propagate adder: combinational sum/carry of two operands plus carry-in, plus a one-stage registered copy with valid flag.
- WIDTH=1 is the classic 1-bit full adder (a+b+cin -> {cout,sum}); wider WIDTH is built as a ripple chain of 1-bit cells.
- Leaf arithmetic block used by datapath adders/counters. The combinational path must be usable with no clock toggling.

Parameters:
- WIDTH, 1, operand/sum bit width (>=1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous active-low reset; sampled on rising clk only.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in into bit 0.
- sum  output  WIDTH  combinational sum, (a+b+cin) mod 2^WIDTH.
- cout  output  1  combinational carry-out of MSB.
- in_valid  input  1  qualifies a/b/cin for the registered stage.
- sum_q  output  WIDTH  registered sum.
- cout_q  output  1  registered carry-out.
- out_valid  output  1  registered in_valid.

Behaviour:
- Port declaration order: a, b, cin, sum, cout first, then clk, rst_n, in_valid, sum_q, cout_q, out_valid. This keeps positional instantiation (a, b, cin, sum, cout) valid.
- Combinational path: {cout,sum} = a + b + cin, computed in WIDTH+1 bits. Zero latency; settles within the same delta/timestep. Independent of clk, rst_n and in_valid.
- Bit cell: s_i = a_i ^ b_i ^ c_i; c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i)); c_0 = cin; cout = c_WIDTH.
- WIDTH=1 truth table for (a,b,cin) -> {cout,sum}:
  - 000->00, 001->01, 010->01, 011->10
  - 100->01, 101->10, 110->10, 111->11
- Registered stage, rising clk:
  - rst_n=0: sum_q=0, cout_q=0, out_valid=0.
  - Otherwise out_valid <= in_valid.
  - When in_valid=1: sum_q <= sum, cout_q <= cout.
  - When in_valid=0: sum_q and cout_q hold their previous values.
- Latency of the registered path is exactly 1 cycle.
- No backpressure; every valid input produces exactly one valid output.
- Reset mid-stream: a valid input presented in a reset cycle is dropped; out_valid=0 the next cycle.
- Overflow wrap: all-ones + all-ones + 1 gives sum = all-ones, cout=1. All-zero inputs give 0 with cout=0.
- X on inputs: no requirement beyond propagation. The reset state contains no X.

Optional Feature:
- Macro FULL_ADDER_OVF_EN.
- When defined: adds outputs ovf (1, combinational) and ovf_q (1, registered, reset 0). ovf = c_WIDTH ^ c_{WIDTH-1} (two's-complement signed overflow). ovf_q follows the same capture/hold rules as cout_q.
- When undefined: neither port exists and no related logic is generated. All other behaviour is identical.

Decomposition:
- Package full_adder_pkg: default width constant (1), and a function computing reference {cout,sum} for checkers.
- One natural sub-module: fa_bit (1-bit cell: a, b, c_in -> s, c_out), instantiated WIDTH times by a generate loop.
- Registers and the optional overflow logic live in full_adder.

Test Plan:
- WIDTH=1, no clock: sweep (a,b,cin) over 000..111 with 1 time unit each -> {cout,sum} = 0,1,1,2,1,2,2,3.
- WIDTH=1, rst_n=0 for 2 cycles with in_valid=1, a=b=cin=1 -> sum_q=0, cout_q=0, out_valid=0. Release reset -> next cycle sum_q=1, cout_q=1, out_valid=1.
- WIDTH=8: a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1. Then a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1 (with FULL_ADDER_OVF_EN).
- WIDTH=8: in_valid pulse with a=0x12, b=0x34, cin=0 -> one cycle later sum_q=0x46, out_valid=1. Next cycle in_valid=0 with a=0xFF -> sum_q stays 0x46, out_valid=0.
- Reset asserted in the same cycle as a valid input (a=3, b=4, WIDTH=8) -> input dropped, outputs 0 the next cycle.
- Random 1000 vectors at WIDTH=16 -> sum/cout match the package reference function; registered outputs match one cycle later.
